// File: rtl/io_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_mon_pkg
//  Description : Shared defaults, LED bit mapping and helpers for the
//                IO activity monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_mon_pkg;

    // Default geometry of the monitor
    localparam int N_CHAN_DEFAULT      = 19;
    localparam int CNT_WIDTH_DEFAULT   = 16;
    localparam int WINDOW_LOG2_DEFAULT = 27;

    // Bit positions of the LEDs inside the internal LED register vector
    localparam int LED_RED_BIT   = 0;
    localparam int LED_GREEN_BIT = 1;
    localparam int LED_BLUE_BIT  = 2;
    localparam int LED_COUNT     = 3;

    // Width of a channel-select field; never narrower than one bit
    function automatic int sel_width(input int n_chan);
        return (n_chan > 1) ? $clog2(n_chan) : 1;
    endfunction

endpackage : io_mon_pkg
`default_nettype wire

// File: rtl/io_chan_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : io_chan_monitor
//  Description : One monitored input: 2-FF synchroniser plus delay stage,
//                both-edge detector, saturating edge counter, per-window
//                seen flag and registered activity flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_chan_monitor
    import io_mon_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk_200,
    input  logic                 reset,
    input  logic                 chan_in,
    input  logic                 clear_cnt,
    input  logic                 window_end,
    output logic                 sync_level,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 saturated,
    output logic                 activity
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_s3;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_seen;
    logic                 r_activity;
    logic                 w_edge;

    // Both rising and falling transitions of the synchronised level count
    assign w_edge = r_s2 ^ r_s3;

    // Synchroniser s1/s2 followed by the s3 delay used for edge detection
    always_ff @(posedge clk_200 or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= chan_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Saturating edge counter; a clear wins over a coincident edge
    always_ff @(posedge clk_200 or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear_cnt) begin
            r_count <= '0;
        end else if (w_edge && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    // Seen flag accumulates over a window; activity captures it at window end
    always_ff @(posedge clk_200 or posedge reset) begin
        if (reset) begin
            r_seen     <= 1'b0;
            r_activity <= 1'b0;
        end else if (window_end) begin
            // An edge on the terminal cycle belongs to the closing window
            r_activity <= r_seen | w_edge;
            r_seen     <= 1'b0;
        end else if (w_edge) begin
            r_seen <= 1'b1;
        end
    end

    assign sync_level = r_s2;
    assign count      = r_count;
    assign saturated  = (r_count == CNT_MAX);
    assign activity   = r_activity;

endmodule : io_chan_monitor
`default_nettype wire

// File: rtl/io_activity_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : io_activity_monitor
//  Description : Monitors N_CHAN asynchronous inputs: per-channel edge
//                counters with readback mux, windowed activity flags,
//                all-inputs-high detect and status LEDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_activity_monitor
    import io_mon_pkg::*;
#(
    parameter  int N_CHAN      = N_CHAN_DEFAULT,
    parameter  int CNT_WIDTH   = CNT_WIDTH_DEFAULT,
    parameter  int WINDOW_LOG2 = WINDOW_LOG2_DEFAULT,
    localparam int SEL_WIDTH   = sel_width(N_CHAN)
) (
    input  logic                 clk_200,
    input  logic                 reset,
    input  logic [N_CHAN-1:0]    chan_in,
    input  logic                 clear_cnt,
    input  logic [SEL_WIDTH-1:0] sel_chan,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic [N_CHAN-1:0]    activity,
    output logic                 all_high,
    output logic                 led_red,
    output logic                 led_green,
    output logic                 led_blue
);

    logic [WINDOW_LOG2-1:0] r_window;
    logic [WINDOW_LOG2-1:0] w_window_next;
    logic                   w_window_end;

    logic [N_CHAN-1:0]      w_sync;
    logic [N_CHAN-1:0]      w_saturated;
    logic [N_CHAN-1:0]      w_activity;
    logic [CNT_WIDTH-1:0]   w_count [N_CHAN];
    logic [CNT_WIDTH-1:0]   w_sel_count;

    logic [CNT_WIDTH-1:0]   r_edge_count;
    logic                   r_all_high;
    logic [LED_COUNT-1:0]   r_leds;

    assign w_window_next = r_window + WINDOW_LOG2'(1);
    assign w_window_end  = &r_window;

    // One monitor per input channel
    generate
        for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
            io_chan_monitor #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_chan (
                .clk_200    (clk_200),
                .reset      (reset),
                .chan_in    (chan_in[gi]),
                .clear_cnt  (clear_cnt),
                .window_end (w_window_end),
                .sync_level (w_sync[gi]),
                .count      (w_count[gi]),
                .saturated  (w_saturated[gi]),
                .activity   (w_activity[gi])
            );
        end
    endgenerate

    // Free-running window counter; wraps from all-ones back to zero
    always_ff @(posedge clk_200 or posedge reset) begin
        if (reset) begin
            r_window <= '0;
        end else begin
            r_window <= w_window_next;
        end
    end

    // Readback select; indices past the last channel read as zero
    always_comb begin
        w_sel_count = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (sel_chan == SEL_WIDTH'(i)) begin
                w_sel_count = w_count[i];
            end
        end
    end

    // Registered readback of the selected counter
    always_ff @(posedge clk_200 or posedge reset) begin
        if (reset) begin
            r_edge_count <= '0;
        end else begin
            r_edge_count <= w_sel_count;
        end
    end

    // AND of all synchronised levels
    always_ff @(posedge clk_200 or posedge reset) begin
        if (reset) begin
            r_all_high <= 1'b0;
        end else begin
            r_all_high <= &w_sync;
        end
    end

    // Status LEDs: saturation, heartbeat (window MSB), any activity
    always_ff @(posedge clk_200 or posedge reset) begin
        if (reset) begin
            r_leds <= '0;
        end else begin
            r_leds[LED_RED_BIT]   <= |w_saturated;
            // Registering the next-count MSB keeps the LED in step with r_window
            r_leds[LED_GREEN_BIT] <= w_window_next[WINDOW_LOG2-1];
            r_leds[LED_BLUE_BIT]  <= |w_activity;
        end
    end

    assign edge_count = r_edge_count;
    assign activity   = w_activity;
    assign all_high   = r_all_high;
    assign led_red    = r_leds[LED_RED_BIT];
    assign led_green  = r_leds[LED_GREEN_BIT];
    assign led_blue   = r_leds[LED_BLUE_BIT];

endmodule : io_activity_monitor
`default_nettype wire

// File: tb/tb_io_activity_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_io_activity_monitor
//  Description : Scoreboard bench for io_activity_monitor (3 channels,
//                4-bit counters, 16-cycle window).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_activity_monitor;

    localparam int NC   = 3;
    localparam int CW   = 4;
    localparam int WL   = 4;
    localparam int WIN  = 1 << WL;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_200   = 1'b0;
    logic          reset     = 1'b1;
    logic [NC-1:0] chan_in   = '0;
    logic          clear_cnt = 1'b0;
    logic [1:0]    sel_chan  = '0;
    logic [CW-1:0] edge_count;
    logic [NC-1:0] activity;
    logic          all_high;
    logic          led_red;
    logic          led_green;
    logic          led_blue;

    int checks = 0;
    int errors = 0;

    io_activity_monitor #(
        .N_CHAN      (NC),
        .CNT_WIDTH   (CW),
        .WINDOW_LOG2 (WL)
    ) dut (
        .clk_200    (clk_200),
        .reset      (reset),
        .chan_in    (chan_in),
        .clear_cnt  (clear_cnt),
        .sel_chan   (sel_chan),
        .edge_count (edge_count),
        .activity   (activity),
        .all_high   (all_high),
        .led_red    (led_red),
        .led_green  (led_green),
        .led_blue   (led_blue)
    );

    always #5 clk_200 = ~clk_200;

    typedef struct {
        logic [NC-1:0] act;
        logic [CW-1:0] cnt;
        logic          ah;
        logic          red;
        logic          green;
        logic          blue;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " activity"},   32'(activity),   32'd0);
        check({tag, " edge_count"}, 32'(edge_count), 32'd0);
        check({tag, " all_high"},   32'(all_high),   32'd0);
        check({tag, " led_red"},    32'(led_red),    32'd0);
        check({tag, " led_green"},  32'(led_green),  32'd0);
        check({tag, " led_blue"},   32'(led_blue),   32'd0);
    endtask

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    // Reference model. Inputs are recorded once per clock; a transition is
    // seen by the counters two clocks after it was first sampled. Counts are
    // "edges since last clear, clipped"; activity is "was the most recent edge
    // inside the 16-clock window that just closed".
    logic [NC-1:0] hist [3];
    int            edges_since_clear [NC];
    int            last_edge_clk [NC];
    int            clk_idx;
    logic [NC-1:0] act_m;

    initial forever begin
        @(posedge clk_200 or posedge reset);
        if (reset) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            for (int i = 0; i < NC; i++) begin
                edges_since_clear[i] = 0;
                last_edge_clk[i]     = -1000;
            end
            clk_idx = 0;
            act_m   = '0;
            sb.delete();
        end else begin
            exp_t          e;
            logic [NC-1:0] trans;
            int            sel;
            logic          any_sat;
            trans   = hist[1] ^ hist[2];
            sel     = int'(sel_chan);
            any_sat = 1'b0;
            for (int i = 0; i < NC; i++)
                if (sat(edges_since_clear[i]) == CMAX) any_sat = 1'b1;
            e.cnt   = (sel < NC) ? CW'(sat(edges_since_clear[sel])) : '0;
            e.red   = any_sat;
            e.blue  = |act_m;
            e.ah    = &hist[1];
            e.green = (((clk_idx + 1) % WIN) >= (WIN / 2));
            for (int i = 0; i < NC; i++) begin
                if (clear_cnt)     edges_since_clear[i] = 0;
                else if (trans[i]) edges_since_clear[i]++;
                if (trans[i])      last_edge_clk[i] = clk_idx;
            end
            if ((clk_idx % WIN) == WIN - 1)
                for (int i = 0; i < NC; i++)
                    act_m[i] = (last_edge_clk[i] > clk_idx - WIN);
            e.act = act_m;
            clk_idx++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = chan_in;
            sb.push_back(e);
        end
    end

    // Monitor: every clock the DUT presents a new output set; compare it
    initial forever begin
        @(negedge clk_200);
        if (reset) begin
            check_all_zero("in_reset");
        end else if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("activity",   32'(activity),   32'(e.act));
            check("edge_count", 32'(edge_count), 32'(e.cnt));
            check("all_high",   32'(all_high),   32'(e.ah));
            check("led_red",    32'(led_red),    32'(e.red));
            check("led_green",  32'(led_green),  32'(e.green));
            check("led_blue",   32'(led_blue),   32'(e.blue));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_200);
            #2;
        end
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(2);

        // Five toggles on channel 1, read back through channel 1
        sel_chan = 2'd1;
        repeat (5) begin
            chan_in[1] = ~chan_in[1];
            tick(4);
        end
        tick(4);
        sel_chan = 2'd0;
        tick(2);
        sel_chan = 2'd2;
        tick(2);

        // Drive channel 0 into saturation, then clear
        sel_chan = 2'd0;
        repeat (20) begin
            chan_in[0] = ~chan_in[0];
            tick(2);
        end
        tick(4);
        clear_cnt = 1'b1;
        tick(1);
        clear_cnt = 1'b0;
        tick(4);

        // Single edges at every window phase, each followed by a quiet window
        sel_chan = 2'd2;
        for (int p = 0; p < 17; p++) begin
            chan_in[2] = ~chan_in[2];
            tick(37);
        end

        // All inputs high, then one drops
        chan_in = '1;
        tick(6);
        chan_in[1] = 1'b0;
        tick(6);

        // Clear coinciding with an edge on channel 0
        chan_in  = '0;
        tick(6);
        sel_chan = 2'd0;
        chan_in[0] = 1'b1;
        tick(2);
        clear_cnt = 1'b1;
        tick(1);
        clear_cnt = 1'b0;
        tick(3);
        sel_chan = 2'd3;
        tick(3);

        // Random traffic
        repeat (400) begin
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 3) == 0) chan_in[i] = ~chan_in[i];
            sel_chan  = 2'($urandom_range(0, 3));
            clear_cnt = ($urandom_range(0, 24) == 0);
            tick(1);
        end
        clear_cnt = 1'b0;

        // Asynchronous reset mid-window with counters and activity nonzero
        repeat (12) begin
            chan_in = ~chan_in;
            tick(1);
        end
        tick(5);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick(2);
        chan_in = '0;
        reset   = 1'b0;
        tick(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_io_activity_monitor
`default_nettype wire
